// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU: accepts one operation at a time,
// alternates grants on ties, and holds the captured result until the consumer takes it.
module alu_arbiter #(
    parameter int DATA_W = 4,
    parameter int OP_W   = 4,
    parameter int RES_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_ena,
    input  logic [RES_W-1:0]  alu_result,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic              rsp_id,

    output logic              busy,
    output logic [7:0]        op_count
);

    // state | meaning
    // IDLE  | waiting for a request; grant is offered combinationally
    // EXEC  | ALU inputs live for exactly one cycle
    // RESP  | result held until rsp_ready
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_grant;
    logic   grant;
    logic   accept;

    // On a tie the port that did not win last time is served; otherwise the lone requester wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = ~req0_valid;
        end
    end

    assign accept = rst_n && (state == IDLE) && (req0_valid || req1_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        alu_ena    = (state == EXEC);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_valid  <= 1'b0;
            op_count   <= 8'h00;
        end else begin
            if (accept) begin
                alu_a      <= grant ? req1_a  : req0_a;
                alu_b      <= grant ? req1_b  : req0_b;
                alu_op     <= grant ? req1_op : req0_op;
                rsp_id     <= grant;
                last_grant <= grant;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_result;
                rsp_valid <= 1'b1;
            end
            if ((state == RESP) && rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU feeds alu_result, and expected responses are queued
// at acceptance and compared when the arbiter presents them.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req0_op, req1_a, req1_b, req1_op;
    logic [3:0] alu_a, alu_b, alu_op;
    logic       alu_ena;
    logic [7:0] alu_result;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data, op_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    logic model_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] op);
        case (op)
            4'h0:    return {4'h0, a} + {4'h0, b};
            4'h1:    return {4'h0, a} - {4'h0, b};
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    alu_arbiter #(.DATA_W(4), .OP_W(4), .RES_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ena(alu_ena),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        model_last = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_op = 4'd0;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd4; req1_op = 4'd1;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready, busy, alu_ena, rsp_valid, rsp_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {req0_ready, req1_ready, busy, alu_ena, rsp_valid, rsp_id});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== 12'h000) begin
            errors++;
            $display("FAIL reset_alu_regs: got %h want 000", {alu_a, alu_b, alu_op});
        end
        checks++;
        if (rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp_data: got %h want 00", rsp_data);
        end
        checks++;
        if (op_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_op_count: got %h want 00", op_count);
        end
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        model_last = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req0_a = 4'd3; req0_b = 4'd5; req0_op = 4'h0; req0_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b100) begin
            errors++;
            $display("FAIL single_grant: got r0,r1,busy=%b want 100", {req0_ready, req1_ready, busy});
        end
        e.id = 1'b0; e.data = 8'h08;
        sb.push_back(e);
        model_last = 1'b0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({alu_ena, rsp_valid, req0_ready, busy} !== 4'b1001) begin
            errors++;
            $display("FAIL single_exec: got ena,rv,r0,busy=%b want 1001",
                     {alu_ena, rsp_valid, req0_ready, busy});
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== {4'd3, 4'd5, 4'h0}) begin
            errors++;
            $display("FAIL single_alu_in: got %h want 350", {alu_a, alu_b, alu_op});
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, alu_ena} !== 2'b10) begin
            errors++;
            $display("FAIL single_latency: got rv,ena=%b want 10", {rsp_valid, alu_ena});
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
            errors++;
            $display("FAIL single_rsp: got id=%0d data=%h want id=%0d data=%h",
                     rsp_id, rsp_data, e.id, e.data);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy, op_count} !== {2'b00, 8'd1}) begin
            errors++;
            $display("FAIL single_done: got rv=%b busy=%b cnt=%0d want 0 0 1",
                     rsp_valid, busy, op_count);
        end
        checks++;
        if ({alu_a, alu_b, alu_op} !== {4'd3, 4'd5, 4'h0}) begin
            errors++;
            $display("FAIL single_alu_hold: got %h want 350", {alu_a, alu_b, alu_op});
        end
    endtask

    task automatic test_tie();
        exp_t e;
        logic exp_g;
        int   n;
        int   acc_cyc;
        apply_reset();
        req0_a = 4'd1; req0_b = 4'd1; req0_op = 4'h0;
        req1_a = 4'd9; req1_b = 4'd2; req1_op = 4'h1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 8) begin
                @(negedge clk);
                n++;
            end
            exp_g = ~model_last;
            checks++;
            if ({req1_ready, req0_ready} !== {exp_g, ~exp_g}) begin
                errors++;
                $display("FAIL tie_grant%0d: got r1,r0=%b want %b", k,
                         {req1_ready, req0_ready}, {exp_g, ~exp_g});
            end
            e.id = exp_g;
            e.data = exp_g ? 8'h07 : 8'h02;
            sb.push_back(e);
            model_last = exp_g;
            acc_cyc = cyc;
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (cyc - acc_cyc != 2) begin
                errors++;
                $display("FAIL tie_latency%0d: got %0d edges want 2", k, cyc - acc_cyc);
            end
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL tie_ready_in_resp%0d: got %b want 00", k, {req0_ready, req1_ready});
            end
            e = sb.pop_front();
            checks++;
            if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                errors++;
                $display("FAIL tie_rsp%0d: got id=%0d data=%h want id=%0d data=%h",
                         k, rsp_id, rsp_data, e.id, e.data);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, op_count} !== {1'b0, 8'd4}) begin
            errors++;
            $display("FAIL tie_count: got busy=%b cnt=%0d want 0 4", busy, op_count);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req1_a = 4'd12; req1_b = 4'd4; req1_op = 4'h1; req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant: got r1,r0=%b want 10", {req1_ready, req0_ready});
        end
        e.id = 1'b1; e.data = 8'h08;
        sb.push_back(e);
        model_last = 1'b1;
        @(posedge clk); #1;
        req0_a = 4'd2; req0_b = 4'd2; req0_op = 4'h0; req0_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
            errors++;
            $display("FAIL bp_rsp: got v=%b id=%0d data=%h want 1 %0d %h",
                     rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy} !==
                {1'b1, e.id, e.data, 3'b001}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b id=%0d data=%h r0=%b r1=%b busy=%b",
                         k, rsp_valid, rsp_id, rsp_data, req0_ready, req1_ready, busy);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy, op_count} !== {2'b00, 8'd5}) begin
            errors++;
            $display("FAIL bp_release: got v=%b busy=%b cnt=%0d want 0 0 5",
                     rsp_valid, busy, op_count);
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int   n;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req0_a = 4'd7; req0_b = 4'd7; req0_op = 4'h0; req0_valid = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_ena !== 1'b1) begin
            errors++;
            $display("FAIL rmo_exec: got alu_ena=%b want 1", alu_ena);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, alu_ena, rsp_valid, rsp_id, req0_ready, req1_ready, alu_a, alu_b, alu_op,
             rsp_data, op_count} !== 34'h0) begin
            errors++;
            $display("FAIL rmo_reset_now: got busy=%b ena=%b v=%b id=%b alu=%h data=%h cnt=%h",
                     busy, alu_ena, rsp_valid, rsp_id, {alu_a, alu_b, alu_op}, rsp_data, op_count);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, op_count} !== 9'h0) begin
            errors++;
            $display("FAIL rmo_held: got v=%b cnt=%0d want 0 0", rsp_valid, op_count);
        end
        #1;
        rst_n = 1'b1;
        model_last = 1'b1;
        req1_a = 4'd5; req1_b = 4'd6; req1_op = 4'h0; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rmo_first_accept: got r1,r0=%b want 10", {req1_ready, req0_ready});
        end
        e.id = 1'b1; e.data = 8'h0B;
        sb.push_back(e);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
            errors++;
            $display("FAIL rmo_rsp: got v=%b id=%0d data=%h want 1 %0d %h",
                     rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
        @(negedge clk);
        checks++;
        if (op_count !== 8'd1) begin
            errors++;
            $display("FAIL rmo_count: got %0d want 1", op_count);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   n;
        int   prev_acc;
        apply_reset();
        prev_acc = 0;
        req0_a = 4'($urandom_range(0, 15));
        req0_b = 4'($urandom_range(0, 15));
        req0_op = 4'($urandom_range(0, 1));
        req0_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            n = 0;
            @(negedge clk);
            while (!req0_ready && n < 8) begin
                @(negedge clk);
                n++;
            end
            if (k > 0) begin
                checks++;
                if (cyc - prev_acc != 3) begin
                    errors++;
                    $display("FAIL wrap_period%0d: got %0d cycles want 3", k, cyc - prev_acc);
                end
            end
            checks++;
            if (op_count !== k[7:0]) begin
                errors++;
                $display("FAIL wrap_count%0d: got %0d want %0d", k, op_count, k[7:0]);
            end
            prev_acc = cyc;
            e.id = 1'b0;
            e.data = alu_model(req0_a, req0_b, req0_op);
            sb.push_back(e);
            @(posedge clk); #1;
            req0_a = 4'($urandom_range(0, 15));
            req0_b = 4'($urandom_range(0, 15));
            req0_op = 4'($urandom_range(0, 1));
            n = 0;
            @(negedge clk);
            while (!rsp_valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            e = sb.pop_front();
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, e.id, e.data}) begin
                errors++;
                $display("FAIL wrap_rsp%0d: got v=%b id=%0d data=%h want 1 %0d %h",
                         k, rsp_valid, rsp_id, rsp_data, e.id, e.data);
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, op_count} !== 9'h000) begin
            errors++;
            $display("FAIL wrap_final: got v=%b cnt=%h want 0 00", rsp_valid, op_count);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b1;
        model_last = 1'b1;
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_reset_mid_op();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 4, operand width of a and b.
REQ-002 Parameter: OP_W, 4, opcode width.
REQ-003 Parameter: RES_W, 8, ALU result width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-007 req0_ready / req1_ready  output  1  operation from requester n accepted this cycle.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands of requester n.
REQ-009 req0_op / req1_op  input  OP_W  opcode of requester n.
REQ-010 alu_a, alu_b  output  DATA_W  registered operands driven to shared ALU.
REQ-011 alu_op  output  OP_W  registered opcode driven to shared ALU.
REQ-012 alu_ena  output  1  high while ALU inputs carry a live operation.
REQ-013 alu_result  input  RES_W  combinational ALU result.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer takes response.
REQ-016 rsp_data  output  RES_W  captured ALU result.
REQ-017 rsp_id  output  1  requester index owning rsp_data.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 op_count  output  8  completed-response counter.

Function
REQ-020 FSM states SHALL be IDLE, EXEC, RESP; one operation in flight at most.
REQ-021 In IDLE with any reqN_valid, the granted port's reqN_ready SHALL be high combinationally that cycle; all other ready low; ready low in EXEC/RESP.
REQ-022 Acceptance = reqN_valid & reqN_ready; on acceptance edge operands/opcode latch into alu_a/alu_b/alu_op, grant index latches into rsp_id, state -> EXEC.
REQ-023 Arbitration: single valid wins; both valid -> port not granted last; last_grant updates only on acceptance.
REQ-024 EXEC lasts exactly one cycle with alu_ena=1; on its closing edge alu_result latches into rsp_data, rsp_valid -> 1, state -> RESP.
REQ-025 Latency: acceptance edge to rsp_valid high = 2 clock edges; minimum 3 cycles per operation with rsp_ready held high.
REQ-026 RESP: rsp_valid, rsp_data, rsp_id SHALL remain stable until rsp_valid & rsp_ready; on that edge rsp_valid -> 0, op_count += 1, state -> IDLE.
REQ-027 No new request is accepted in the cycle the response is consumed; next acceptance earliest in following IDLE cycle.
REQ-028 op_count SHALL wrap 8'hFF -> 8'h00 without flag.
REQ-029 alu_a/alu_b/alu_op SHALL hold last operation values outside EXEC; alu_ena=0 outside EXEC.
REQ-030 reqN_valid dropped while not granted SHALL have no effect; no request state is stored outside acceptance.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, last_grant=1 (port 0 wins first tie), alu_a/alu_b/alu_op=0, alu_ena=0, rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0; busy=0, ready outputs low while rst_n low.
REQ-032 Reset asserted in EXEC or RESP SHALL discard the in-flight operation; no response is produced afterwards and op_count does not increment.
REQ-033 First acceptance possible in first IDLE cycle after rst_n deasserts.

Verification (bench ALU model: op 4'h0 -> a+b, op 4'h1 -> a-b mod 256)
REQ-034 Single request: req0 a=3,b=5,op=0, rsp_ready=1 -> req0_ready same cycle, alu_ena one cycle, rsp_valid 2 edges later with rsp_data=8'h08, rsp_id=0, op_count=1.
REQ-035 Tie after reset: both valid (req0 a=1,b=1,op=0; req1 a=9,b=2,op=1) held -> responses in order id0 data 8'h02, then id1 data 8'h07; repeat tie -> grants alternate 0,1,0,1.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_id stable, both ready low, busy=1; rsp_ready=1 -> consumed in one edge, IDLE next cycle.
REQ-037 Reset mid-op: rst_n low during EXEC -> rsp_valid stays 0, op_count=0, all outputs at REQ-031 values immediately.
REQ-038 Counter wrap: 256 back-to-back ops with rsp_ready=1 -> op_count returns to 8'h00, each op 3 cycles.
